// File: rtl/bus_wait_ctrl.sv
// bus_wait_ctrl: decodes the CPU bus into ROM/RAM/IO selects and holds n_rdy high for per-region wait states.
// Latency: n_rdy low 2+WAIT edges after access start; IO additionally waits for n_io_rdy low.
// Flow control: the CPU is stalled via n_rdy; optional BUS_TIMEOUT_EN bounds IO waits to TIMEOUT cycles.
module bus_wait_ctrl #(
  parameter logic [15:0] RAM_BASE = 16'h8000,
  parameter logic [15:0] IO_BASE  = 16'hFF00,
  parameter int unsigned ROM_WAIT = 2,
  parameter int unsigned RAM_WAIT = 0,
  parameter int unsigned IO_WAIT  = 1,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [15:0] a,
  input  logic        n_oe,
  input  logic        n_we,
  output logic        n_rdy,
  output logic        n_cs_rom,
  output logic        n_cs_ram,
  output logic        n_cs_io,
  input  logic        n_io_rdy,
  output logic        bus_err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READY} state_t;
  typedef enum logic [1:0] {R_NONE, R_ROM, R_RAM, R_IO} region_t;

  localparam logic [3:0] ROM_W = 4'(ROM_WAIT);
  localparam logic [3:0] RAM_W = 4'(RAM_WAIT);
  localparam logic [3:0] IO_W  = 4'(IO_WAIT);

  state_t     state, state_nxt;
  region_t    region, region_nxt, a_region;
  logic [3:0] cnt, cnt_nxt, a_wait;
  logic       dir_we, dir_we_nxt;
  logic       bus_err_nxt, n_rdy_nxt;
  logic       n_cs_rom_nxt, n_cs_ram_nxt, n_cs_io_nxt;
  logic       single, conflict, released, active_nxt;

`ifdef BUS_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] tcnt, tcnt_nxt;
`endif

  assign single   = n_oe ^ n_we;
  assign conflict = ~n_oe & ~n_we;
  assign released = n_oe & n_we;

  always_comb begin
    a_region = R_IO;
    a_wait   = IO_W;
    if (a < RAM_BASE) begin
      a_region = R_ROM;
      a_wait   = ROM_W;
    end else if (a < IO_BASE) begin
      a_region = R_RAM;
      a_wait   = RAM_W;
    end
  end

  always_comb begin
    state_nxt   = state;
    region_nxt  = region;
    cnt_nxt     = cnt;
    dir_we_nxt  = dir_we;
    bus_err_nxt = bus_err;
`ifdef BUS_TIMEOUT_EN
    tcnt_nxt    = tcnt;
`endif
    case (state)
      S_IDLE: begin
        if (single) begin
          state_nxt  = S_WAIT;
          region_nxt = a_region;
          cnt_nxt    = a_wait;
          dir_we_nxt = ~n_we;
`ifdef BUS_TIMEOUT_EN
          tcnt_nxt   = '0;
`endif
        end else if (conflict) begin
          // Complete the cycle without selecting anything so the CPU cannot hang.
          state_nxt   = S_READY;
          region_nxt  = R_NONE;
          bus_err_nxt = 1'b1;
        end
      end
      S_WAIT: begin
        if (released) begin
          state_nxt  = S_IDLE;
          region_nxt = R_NONE;
        end else if (cnt == 4'd0 && (region != R_IO || !n_io_rdy)) begin
          state_nxt = S_READY;
`ifdef BUS_TIMEOUT_EN
        end else if (region == R_IO && tcnt == TO_LAST) begin
          state_nxt   = S_READY;
          bus_err_nxt = 1'b1;
`endif
        end else begin
          if (cnt != 4'd0) cnt_nxt = cnt - 4'd1;
`ifdef BUS_TIMEOUT_EN
          if (region == R_IO) tcnt_nxt = tcnt + 8'd1;
`endif
        end
      end
      S_READY: begin
        if (released) begin
          state_nxt  = S_IDLE;
          region_nxt = R_NONE;
        end
      end
      default: begin
        state_nxt  = S_IDLE;
        region_nxt = R_NONE;
      end
    endcase

    // Selects follow the latched region; ROM writes are never presented to the ROM.
    active_nxt   = (state_nxt != S_IDLE);
    n_rdy_nxt    = (state_nxt != S_READY);
    n_cs_rom_nxt = !(active_nxt && region_nxt == R_ROM && !dir_we_nxt);
    n_cs_ram_nxt = !(active_nxt && region_nxt == R_RAM);
    n_cs_io_nxt  = !(active_nxt && region_nxt == R_IO);
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state    <= S_IDLE;
      region   <= R_NONE;
      cnt      <= '0;
      dir_we   <= 1'b0;
      n_rdy    <= 1'b1;
      n_cs_rom <= 1'b1;
      n_cs_ram <= 1'b1;
      n_cs_io  <= 1'b1;
      bus_err  <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      tcnt     <= '0;
`endif
    end else begin
      state    <= state_nxt;
      region   <= region_nxt;
      cnt      <= cnt_nxt;
      dir_we   <= dir_we_nxt;
      n_rdy    <= n_rdy_nxt;
      n_cs_rom <= n_cs_rom_nxt;
      n_cs_ram <= n_cs_ram_nxt;
      n_cs_io  <= n_cs_io_nxt;
      bus_err  <= bus_err_nxt;
`ifdef BUS_TIMEOUT_EN
      tcnt     <= tcnt_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_bus_wait_ctrl.sv
// Bench for bus_wait_ctrl: directed literal checks plus randomized traffic against an access-level model.
// BUS_TIMEOUT_EN selects the timeout expectations.
module tb_bus_wait_ctrl;

  localparam int ROM_W = 2;
  localparam int RAM_W = 0;
  localparam int IO_W  = 1;
  localparam int TO    = 64;
`ifdef BUS_TIMEOUT_EN
  localparam bit TO_ON = 1'b1;
`else
  localparam bit TO_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic [15:0] a = 16'h0000;
  logic        n_oe = 1'b1;
  logic        n_we = 1'b1;
  logic        n_io_rdy = 1'b1;
  logic        n_rdy, n_cs_rom, n_cs_ram, n_cs_io, bus_err;

  int checks = 0;
  int errors = 0;

  bus_wait_ctrl #(
    .RAM_BASE(16'h8000), .IO_BASE(16'hFF00),
    .ROM_WAIT(ROM_W), .RAM_WAIT(RAM_W), .IO_WAIT(IO_W), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .n_rst(n_rst), .a(a), .n_oe(n_oe), .n_we(n_we),
    .n_rdy(n_rdy), .n_cs_rom(n_cs_rom), .n_cs_ram(n_cs_ram), .n_cs_io(n_cs_io),
    .n_io_rdy(n_io_rdy), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Access-level model: an access is open from its start edge until the
  // strobes are released; it is "completed" once enough wait edges have
  // elapsed for its region (and, for IO, the peripheral reported ready).
  typedef enum int {REG_NONE, REG_ROM, REG_RAM, REG_IO} mreg_t;
  bit    m_valid = 0;
  bit    m_open = 0;
  bit    m_done = 0;
  bit    m_write = 0;
  bit    m_err = 0;
  mreg_t m_reg = REG_NONE;
  int    m_age = 0;

  function automatic mreg_t decode(input logic [15:0] addr);
    if (addr < 16'h8000) return REG_ROM;
    if (addr < 16'hFF00) return REG_RAM;
    return REG_IO;
  endfunction

  function automatic int waits_of(input mreg_t r);
    case (r)
      REG_ROM: return ROM_W;
      REG_RAM: return RAM_W;
      default: return IO_W;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!n_rst) begin
      m_valid = 1; m_open = 0; m_done = 0; m_err = 0; m_reg = REG_NONE; m_age = 0;
    end else if (!m_open) begin
      if (n_oe != n_we) begin
        m_open = 1; m_done = 0; m_reg = decode(a); m_write = !n_we; m_age = 0;
      end else if (!n_oe && !n_we) begin
        m_open = 1; m_done = 1; m_reg = REG_NONE; m_err = 1;
      end
    end else if (n_oe && n_we) begin
      m_open = 0; m_done = 0; m_reg = REG_NONE;
    end else if (!m_done) begin
      if (m_age >= waits_of(m_reg) && (m_reg != REG_IO || !n_io_rdy))
        m_done = 1;
      else if (TO_ON && m_reg == REG_IO && m_age == TO - 1) begin
        m_done = 1; m_err = 1;
      end else
        m_age++;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("n_rdy", n_rdy, !(m_open && m_done));
      chk("n_cs_rom", n_cs_rom, !(m_open && m_reg == REG_ROM && !m_write));
      chk("n_cs_ram", n_cs_ram, !(m_open && m_reg == REG_RAM));
      chk("n_cs_io", n_cs_io, !(m_open && m_reg == REG_IO));
      chk("bus_err", bus_err, m_err);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] edges [4];

  initial begin
    edges[0] = 16'h7FFF; edges[1] = 16'h8000; edges[2] = 16'hFEFF; edges[3] = 16'hFF00;

    // Reset held two cycles with a read strobe active.
    n_rst = 1'b0; n_oe = 1'b0; a = 16'h8123;
    step(); step();
    chk("rst_n_rdy", n_rdy, 1'b1);
    chk("rst_cs_rom", n_cs_rom, 1'b1);
    chk("rst_cs_ram", n_cs_ram, 1'b1);
    chk("rst_cs_io", n_cs_io, 1'b1);
    chk("rst_bus_err", bus_err, 1'b0);
    n_rst = 1'b1; n_oe = 1'b1;
    step();

    // RAM read, zero wait states.
    a = 16'h8123; n_oe = 1'b0;
    step();
    chk("ram_cs_e1", n_cs_ram, 1'b0);
    chk("ram_rdy_e1", n_rdy, 1'b1);
    step();
    chk("ram_rdy_e2", n_rdy, 1'b0);
    n_oe = 1'b1;
    step();
    chk("ram_rdy_rel", n_rdy, 1'b1);
    chk("ram_cs_rel", n_cs_ram, 1'b1);

    // ROM write: select suppressed, completes at edge+4.
    a = 16'h0010; n_we = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("romw_rdy_wait", n_rdy, 1'b1);
      chk("romw_cs", n_cs_rom, 1'b1);
    end
    step();
    chk("romw_rdy_e4", n_rdy, 1'b0);
    chk("romw_cs_e4", n_cs_rom, 1'b1);
    n_we = 1'b1;
    step();
    chk("romw_rdy_rel", n_rdy, 1'b1);

    // Slow IO device; address moves mid-wait.
    a = 16'hFF05; n_oe = 1'b0; n_io_rdy = 1'b1;
    step();
    chk("io_cs_e1", n_cs_io, 1'b0);
    a = 16'h0000;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("io_rdy_slow", n_rdy, 1'b1);
      chk("io_cs_hold", n_cs_io, 1'b0);
      chk("io_rom_quiet", n_cs_rom, 1'b1);
    end
    n_io_rdy = 1'b0;
    step();
    chk("io_rdy_done", n_rdy, 1'b0);
    n_oe = 1'b1; n_io_rdy = 1'b1;
    step();
    chk("io_rdy_rel", n_rdy, 1'b1);
    chk("io_cs_rel", n_cs_io, 1'b1);

    // Strobe conflict.
    n_oe = 1'b0; n_we = 1'b0;
    step();
    chk("cfl_err", bus_err, 1'b1);
    chk("cfl_rdy", n_rdy, 1'b0);
    chk("cfl_cs_rom", n_cs_rom, 1'b1);
    chk("cfl_cs_ram", n_cs_ram, 1'b1);
    chk("cfl_cs_io", n_cs_io, 1'b1);
    n_oe = 1'b1; n_we = 1'b1;
    step();
    chk("cfl_rdy_rel", n_rdy, 1'b1);
    chk("cfl_err_sticky", bus_err, 1'b1);
    n_rst = 1'b0;
    step();
    chk("cfl_err_clear", bus_err, 1'b0);
    n_rst = 1'b1;
    step();

    // Aborted ROM read.
    a = 16'h0100; n_oe = 1'b0;
    step();
    chk("abt_cs_e1", n_cs_rom, 1'b0);
    n_oe = 1'b1;
    step();
    chk("abt_cs_drop", n_cs_rom, 1'b1);
    chk("abt_rdy", n_rdy, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("abt_no_pulse", n_rdy, 1'b1);
    end

    // IO with a peripheral that never answers.
    a = 16'hFF80; n_oe = 1'b0; n_io_rdy = 1'b1;
    step();
`ifdef BUS_TIMEOUT_EN
    for (int i = 0; i < TO - 1; i++) begin
      step();
      chk("to_rdy_wait", n_rdy, 1'b1);
    end
    step();
    chk("to_rdy_forced", n_rdy, 1'b0);
    chk("to_err", bus_err, 1'b1);
`else
    for (int i = 0; i < 200; i++) begin
      step();
      chk("noto_rdy_wait", n_rdy, 1'b1);
    end
    chk("noto_err", bus_err, 1'b0);
`endif
    n_oe = 1'b1;
    step();
    n_rst = 1'b0;
    step();
    n_rst = 1'b1;

    // Randomized traffic, checked every cycle by the model.
    for (int c = 0; c < 4000; c++) begin
      n_rst = ($urandom_range(0, 149) != 0);
      if ($urandom_range(0, 4) == 0) begin
        case ($urandom_range(0, 19))
          0,1,2,3,4,5,6,7: {n_oe, n_we} = 2'b11;
          8,9,10,11,12,13: {n_oe, n_we} = 2'b01;
          14,15,16,17,18: {n_oe, n_we} = 2'b10;
          default: {n_oe, n_we} = 2'b00;
        endcase
      end
      case ($urandom_range(0, 3))
        0: a = 16'($urandom_range(16'h0000, 16'h7FFF));
        1: a = 16'($urandom_range(16'h8000, 16'hFEFF));
        2: a = 16'($urandom_range(16'hFF00, 16'hFFFF));
        default: a = edges[$urandom_range(0, 3)];
      endcase
      n_io_rdy = ($urandom_range(0, 3) != 0);
      step();
    end

    n_oe = 1'b1; n_we = 1'b1;
    step(); step();
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_wait_ctrl.md
Name: bus_wait_ctrl

Overview:
- Downstream of the CPU core. Consumes the CPU external bus (a, n_oe, n_we) and produces the core's n_rdy input.
- Decodes the address into ROM / RAM / IO chip selects.
- Inserts a per-region programmable number of wait states. IO accesses additionally wait for a peripheral ready line.
- Sits between the CPU top and the board memories/peripherals. This is the only source of n_rdy.

Parameters:
- RAM_BASE, 16'h8000, first RAM address; below it is ROM.
- IO_BASE, 16'hFF00, first IO address; RAM is RAM_BASE..IO_BASE-1.
- ROM_WAIT, 2, wait cycles for ROM accesses (0..15).
- RAM_WAIT, 0, wait cycles for RAM accesses (0..15).
- IO_WAIT, 1, minimum wait cycles for IO accesses (0..15).
- TIMEOUT, 64, IO ready timeout in cycles (used only with BUS_TIMEOUT_EN; 1..255).

Ports:
- clk  input  1  system clock, same clock as the CPU core.
- n_rst  input  1  reset.
- a  input  16  CPU address bus.
- n_oe  input  1  CPU read strobe, active low.
- n_we  input  1  CPU write strobe, active low.
- n_rdy  output  1  ready to CPU, active low; registered.
- n_cs_rom  output  1  ROM chip select, active low.
- n_cs_ram  output  1  RAM chip select, active low.
- n_cs_io  output  1  IO chip select, active low.
- n_io_rdy  input  1  peripheral ready, active low; synchronous to clk.
- bus_err  output  1  sticky error flag, active high; registered.

Interface (already decided): one clock, clk. Reset n_rst is synchronous and active-low, sampled on rising edge of clk.

Behaviour:
- Reset (n_rst low at a clk edge): state IDLE, n_rdy=1, n_cs_rom/ram/io=1, bus_err=0, wait counter=0, latched region=none. Applies identically mid-access; the next cycle restarts from IDLE.
- Access start: in IDLE, a rising edge with exactly one of n_oe/n_we low.
  - Latches the region from a: ROM if a<RAM_BASE, RAM if a<IO_BASE, else IO.
  - Loads counter with that region's WAIT.
  - Latches the direction.
- Chip selects are registered and driven from the latched region.
  - Asserted the cycle after access start; held through WAIT and READY.
  - Deasserted on return to IDLE.
  - Address changes after start do not affect region or chip selects.
- ROM write: n_cs_rom stays 1 (write suppressed). Timing is the same as a ROM read, so the CPU completes normally.
- Conflict (n_oe and n_we both low in IDLE): no chip select, bus_err set, go to READY directly so the CPU cannot hang.
- States:
  - IDLE -> WAIT on access start.
  - WAIT: counter decrements each cycle. When counter==0 (and, for IO, n_io_rdy==0 sampled), go to READY. WAIT with counter loaded 0 lasts one cycle.
  - READY: n_rdy=0. Stays until both n_oe and n_we are high, then -> IDLE with n_rdy=1.
  - Strobes released during WAIT (aborted cycle): -> IDLE, no n_rdy pulse, chip selects drop.
- Latency: n_rdy goes low at edge start+2+WAIT, e.g. RAM_WAIT=0 -> low 2 edges after the start edge. IO: max of IO_WAIT countdown and first n_io_rdy low.
- Back-to-back: a new access is recognised only in IDLE. At least one IDLE cycle separates accesses.
- bus_err: sticky until reset.

Optional Feature:
- Macro BUS_TIMEOUT_EN.
- Defined: an 8-bit timeout counter runs while in WAIT for IO. If it reaches TIMEOUT before n_io_rdy is low, force READY, set bus_err, and return read data undefined.
- Undefined: no timeout counter. IO WAIT persists indefinitely until n_io_rdy=0. bus_err is set only by a strobe conflict.

Test Plan:
- Reset: hold n_rst=0 two cycles with n_oe=0 -> n_rdy=1, all n_cs_*=1, bus_err=0.
- RAM read: a=16'h8123, n_oe=0, RAM_WAIT=0 -> n_cs_ram=0 from edge+1, n_rdy=0 at edge+2. Release n_oe -> n_rdy=1 and n_cs_ram=1 next edge.
- ROM write: a=16'h0010, n_we=0, ROM_WAIT=2 -> n_cs_rom stays 1, n_rdy=0 at edge+4.
- IO slow device: a=16'hFF05, n_oe=0, n_io_rdy held 1 for 10 cycles -> n_rdy stays 1. Drop n_io_rdy -> n_rdy=0 one edge later. Change a to 16'h0000 mid-wait -> n_cs_io stays 0.
- Conflict and abort:
  - n_oe=n_we=0 -> bus_err=1, n_rdy=0, no chip select.
  - Separately, release n_oe during a ROM wait -> IDLE, no n_rdy pulse.
- Timeout (BUS_TIMEOUT_EN, TIMEOUT=64): IO read with n_io_rdy stuck 1 -> n_rdy=0 and bus_err=1 after 64 WAIT cycles. Without the macro, n_rdy stays 1 for 200 cycles.
